mem_clr_ram: RTL
================

Name: mem_clr_ram

Overview:
- Parametrised single-port RAM; the next generation of the lab's 256x8 memory.
- Adds a hardware clear sequencer that sweeps every word to CLR_VALUE, one word per cycle, after reset or on request.
- Asserts busy while sweeping. User writes are blocked during a sweep.
- Serves as the backing store for the heap datapath, so the heap always starts from a known-clean memory.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 256, number of words; need not be a power of two (minimum 2).
- ADDR_SIZE, $clog2(DEPTH), address width (derived; do not override).
- CLR_VALUE, {WIDTH{1'b0}}, value written to every word by a sweep.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_SIZE  user read/write address.
- wen  input  1  user write enable.
- din  input  WIDTH  user write data.
- clr_req  input  1  request a full-memory clear; single-cycle pulse or level.
- dout  output  WIDTH  read data at addr.
- busy  output  1  high while the sweep runs; user writes are ignored while high.
- clr_done  output  1  one-cycle pulse on the final sweep write.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk.
- FSM states: IDLE, CLEAR.
- While reset=1: state<=CLEAR, clr_addr<=0, clr_done<=0, no memory write. busy=1 during reset and after it.
- CLEAR, each cycle:
  - mem[clr_addr]<=CLR_VALUE; busy=1.
  - If clr_addr==DEPTH-1: state<=IDLE, clr_done pulses 1 in that cycle.
  - Otherwise clr_addr<=clr_addr+1.
- Sweep length is exactly DEPTH cycles after reset deasserts.
- IDLE:
  - busy=0.
  - wen=1 and addr<DEPTH: mem[addr]<=din at the edge.
  - clr_req=1: state<=CLEAR, clr_addr<=0, starting next cycle.
- Simultaneous events and boundaries:
  - clr_req and wen in the same IDLE cycle: the clear wins and the write is dropped.
  - clr_req during CLEAR: ignored; the sweep does not restart.
  - wen during CLEAR: ignored; no write occurs.
  - reset mid-sweep: the sweep restarts from address 0.
  - addr>=DEPTH (non-power-of-two DEPTH): writes are ignored and dout=0.
- Read path: dout=mem[addr], combinational, zero latency. Read-during-write returns the old data until the edge.
- During CLEAR, reads are allowed and return the current contents, already-cleared or not.
- Memory contents are not reset directly; they are defined only by the sweep.
- clr_done is registered (reset 0) and is never high in two consecutive cycles.

Optional Feature:
- Macro: MEM_CLR_RAM_RDREG_EN.
- Defined: dout is registered, so dout at edge N+1 = mem[addr sampled at edge N]. Read latency is 1.
  - Read-during-write to the same address returns the new din (write-first).
  - Reset value of dout is 0.
  - addr>=DEPTH registers 0.
- Undefined: combinational read, as described above.

Decomposition:
- Package mem_pkg:
  - state typedef (IDLE, CLEAR).
  - default WIDTH/DEPTH localparams.
- Sub-module mem_clr_seq:
  - Holds the FSM, clr_addr counter, busy and clr_done.
  - Outputs the sweep write enable and address.
- mem_clr_ram holds the array and muxes sweep vs user writes; the sweep has priority.

Test Plan:
- Reset, then clear: hold reset 3 cycles, release. busy=1 for exactly 256 cycles; clr_done pulses once, on the cycle writing addr 255. Reading addrs 0..255 then returns 0x00.
- Write/read: in IDLE write 0xA5 to 0x10 and 0x3C to 0xFF. dout reads back 0xA5 and 0x3C. In combinational mode, dout changes on the same cycle addr changes.
- Clear request: write 0x77 to 0x42, pulse clr_req. busy rises the next cycle, wen=1/din=0x99 at 0x05 during the sweep is ignored, and after clr_done 0x42 and 0x05 both read 0x00.
- Clear beats write: clr_req=1 and wen=1 (0x55 to 0x20) in the same cycle. 0x20 reads 0x00 after the sweep. A second clr_req mid-sweep does not extend busy beyond 256 cycles.
- Reset mid-sweep and odd depth: with DEPTH=100, assert reset at sweep cycle 50. busy lasts 100 cycles after release. A write to addr 110 is ignored and reading 110 returns 0.
- With MEM_CLR_RAM_RDREG_EN defined: dout is 0 out of reset. Writing 0xC3 to 0x08 while addr=0x08 gives dout=0xC3 one cycle later (write-first). Address changes appear on dout one cycle late.

Source files
------------

// File: rtl/mem_clr_ram_pkg.sv
// Shared definitions for the clearable RAM: default geometry and sequencer state encoding.
package mem_pkg;

  localparam int MEM_WIDTH = 8;
  localparam int MEM_DEPTH = 256;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

endpackage : mem_pkg

// File: rtl/mem_clr_ram_if.sv
// User-side bus of the clearable RAM: address/write/clear request in, read data and status out.
interface mem_clr_ram_if
  import mem_pkg::*;
#(
  parameter int WIDTH     = MEM_WIDTH,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
);

  logic [ADDR_SIZE-1:0] addr;
  logic                 wen;
  logic [WIDTH-1:0]     din;
  logic                 clr_req;
  logic [WIDTH-1:0]     dout;
  logic                 busy;
  logic                 clr_done;

  modport master (
    output addr, wen, din, clr_req,
    input  dout, busy, clr_done
  );

  modport slave (
    input  addr, wen, din, clr_req,
    output dout, busy, clr_done
  );

endinterface : mem_clr_ram_if

// File: rtl/mem_clr_ram_clr_seq.sv
// Clear sequencer: walks clr_addr over every word after reset or on request,
// driving the sweep write strobe, busy and the final-write clr_done pulse.
module mem_clr_seq
  import mem_pkg::*;
#(
  parameter int DEPTH     = MEM_DEPTH,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_req_i,
  output logic                 busy_o,
  output logic                 clr_done_o,
  output logic                 swp_we_o,
  output logic [ADDR_SIZE-1:0] swp_addr_o
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  state_t               state_q,    state_d;
  logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;
  logic                 busy_q,     busy_d;
  logic                 clr_done_q, clr_done_d;

  // Next-state logic; clr_done is precomputed so it is high in the cycle that writes the last word.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = {ADDR_SIZE{1'b0}};
        end else begin
          clr_addr_d = clr_addr_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d    = ST_CLEAR;
          clr_addr_d = {ADDR_SIZE{1'b0}};
        end else begin
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = {ADDR_SIZE{1'b0}};
      end
    endcase
    busy_d     = (state_d == ST_CLEAR);
    clr_done_d = (state_d == ST_CLEAR) && (clr_addr_d == LAST_ADDR);
  end

  // State registers; reset (re)starts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= {ADDR_SIZE{1'b0}};
      busy_q     <= 1'b1;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign busy_o     = busy_q;
  assign clr_done_o = clr_done_q;
  assign swp_we_o   = (state_q == ST_CLEAR) && !reset;
  assign swp_addr_o = clr_addr_q;

endmodule : mem_clr_seq

// File: rtl/mem_clr_ram.sv
// Single-port RAM with a hardware clear sweep; the sweep owns the write port while busy.
// Define MEM_CLR_RAM_RDREG_EN for a registered, write-first read port (latency 1).
module mem_clr_ram
  import mem_pkg::*;
#(
  parameter int               WIDTH     = MEM_WIDTH,
  parameter int               DEPTH     = MEM_DEPTH,
  parameter int               ADDR_SIZE = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}}
) (
  input logic          clk,
  input logic          reset,
  mem_clr_ram_if.slave bus_if
);

  localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic                 swp_we_s;
  logic [ADDR_SIZE-1:0] swp_addr_s;
  logic                 busy_s;
  logic                 clr_done_s;
  logic                 addr_ok_s;
  logic                 usr_we_s;
  logic                 mem_we_s;
  logic [ADDR_SIZE-1:0] wr_addr_s;
  logic [WIDTH-1:0]     wr_data_s;
  logic [WIDTH-1:0]     rd_data_s;

  mem_clr_seq #(
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_clr_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_req_i  (bus_if.clr_req),
    .busy_o     (busy_s),
    .clr_done_o (clr_done_s),
    .swp_we_o   (swp_we_s),
    .swp_addr_o (swp_addr_s)
  );

  // A clear request in the same cycle drops the user write.
  assign addr_ok_s = ({1'b0, bus_if.addr} < DEPTH_W);
  assign usr_we_s  = !busy_s && bus_if.wen && !bus_if.clr_req && addr_ok_s && !reset;

  // Write-port mux; the sweep has priority over the user.
  always_comb begin
    mem_we_s  = 1'b0;
    wr_addr_s = bus_if.addr;
    wr_data_s = bus_if.din;
    if (swp_we_s) begin
      mem_we_s  = 1'b1;
      wr_addr_s = swp_addr_s;
      wr_data_s = CLR_VALUE;
    end else begin
      mem_we_s  = usr_we_s;
    end
  end

  // Storage array; contents are defined only by writes and the sweep.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    rd_data_s = {WIDTH{1'b0}};
    if (addr_ok_s) begin
      rd_data_s = mem_q[bus_if.addr];
    end else begin
      rd_data_s = {WIDTH{1'b0}};
    end
  end

`ifdef MEM_CLR_RAM_RDREG_EN
  logic [WIDTH-1:0] dout_q;

  // Registered read port, forwarding same-address write data.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= {WIDTH{1'b0}};
    end else if (!addr_ok_s) begin
      dout_q <= {WIDTH{1'b0}};
    end else if (mem_we_s && (wr_addr_s == bus_if.addr)) begin
      dout_q <= wr_data_s;
    end else begin
      dout_q <= rd_data_s;
    end
  end

  assign bus_if.dout = dout_q;
`else
  assign bus_if.dout = rd_data_s;
`endif

  assign bus_if.busy     = busy_s;
  assign bus_if.clr_done = clr_done_s;

endmodule : mem_clr_ram
